// File: rtl/dma_desc_pkg.sv
// dma_desc_pkg: descriptor field positions and the ring slot lifecycle states.
package dma_desc_pkg;
    localparam int DESC_ADDR_LSB  = 0;
    localparam int DESC_LEN_LSB   = 64;
    localparam int DESC_EMPTY_BIT = 96;
    localparam int DESC_TS_LSB    = 97;
    localparam int DESC_WIDTH     = 128;
    typedef enum logic [1:0] {FREE, LOADED, ISSUED, DONE} slot_state_e;
endpackage

// File: rtl/dma_desc_ring_if.sv
// dma_desc_ring_if: fetch, issue, completion and writeback signals of the descriptor ring.
interface dma_desc_ring_if #(
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int AXIS_DATA_WIDTH = 64,
    parameter int LEN_WIDTH       = 16,
    parameter int TAG_WIDTH       = 2
);
    logic [AXIS_DATA_WIDTH-1:0] s_axis_desc_tdata;
    logic                       s_axis_desc_tvalid;
    logic                       s_axis_desc_tready;
    logic [AXI_ADDR_WIDTH-1:0]  m_desc_addr;
    logic [LEN_WIDTH-1:0]       m_desc_len;
    logic [TAG_WIDTH-1:0]       m_desc_tag;
    logic                       m_desc_valid;
    logic                       m_desc_ready;
    logic [LEN_WIDTH-1:0]       s_axis_dma_desc_length;
    logic [TAG_WIDTH-1:0]       s_axis_dma_desc_tag;
    logic                       s_axis_dma_desc_valid;
    logic [AXIS_DATA_WIDTH-1:0] m_axis_wb_tdata;
    logic                       m_axis_wb_tvalid;
    logic                       m_axis_wb_tready;
    logic                       m_axis_wb_tlast;
    modport slave (
        input  s_axis_desc_tdata, s_axis_desc_tvalid, m_desc_ready,
        input  s_axis_dma_desc_length, s_axis_dma_desc_tag, s_axis_dma_desc_valid, m_axis_wb_tready,
        output s_axis_desc_tready, m_desc_addr, m_desc_len, m_desc_tag, m_desc_valid,
        output m_axis_wb_tdata, m_axis_wb_tvalid, m_axis_wb_tlast
    );
    modport master (
        output s_axis_desc_tdata, s_axis_desc_tvalid, m_desc_ready,
        output s_axis_dma_desc_length, s_axis_dma_desc_tag, s_axis_dma_desc_valid, m_axis_wb_tready,
        input  s_axis_desc_tready, m_desc_addr, m_desc_len, m_desc_tag, m_desc_valid,
        input  m_axis_wb_tdata, m_axis_wb_tvalid, m_axis_wb_tlast
    );
endinterface

// File: rtl/dma_desc_slot.sv
// dma_desc_slot: one ring entry, a 128-bit descriptor plus its FREE/LOADED/ISSUED/DONE state.
// With DMA_DESC_TIMESTAMP_EN a completion also stamps bits [127:97].
module dma_desc_slot
    import dma_desc_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH = 64,
    parameter int LEN_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load_i,
    input  logic                       beat_i,
    input  logic                       last_i,
    input  logic [AXIS_DATA_WIDTH-1:0] data_i,
    input  logic                       issue_i,
    input  logic                       complete_i,
    input  logic [LEN_WIDTH-1:0]       len_i,
`ifdef DMA_DESC_TIMESTAMP_EN
    input  logic [30:0]                ts_i,
`endif
    input  logic                       free_i,
    output logic [DESC_WIDTH-1:0]      desc_o,
    output slot_state_e                state_o
);
    logic [DESC_WIDTH-1:0] desc_q, desc_d;
    slot_state_e state_q, state_d;
    always_comb begin
        desc_d  = desc_q;
        state_d = state_q;
        if (load_i) begin
            desc_d[int'(beat_i)*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH] = data_i;
            // Software-owned descriptors bypass the DMA and go straight to writeback
            if (last_i) state_d = desc_d[DESC_EMPTY_BIT] ? LOADED : DONE;
        end
        if (issue_i) state_d = ISSUED;
        if (complete_i) begin
            desc_d[DESC_LEN_LSB +: 32] = 32'(len_i);
            desc_d[DESC_EMPTY_BIT]     = 1'b0;
`ifdef DMA_DESC_TIMESTAMP_EN
            desc_d[DESC_WIDTH-1:DESC_TS_LSB] = ts_i;
`endif
            state_d = DONE;
        end
        if (free_i) state_d = FREE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            desc_q  <= '0;
            state_q <= FREE;
        end else begin
            desc_q  <= desc_d;
            state_q <= state_d;
        end
    end
    assign desc_o  = desc_q;
    assign state_o = state_q;
endmodule

// File: rtl/dma_desc_ring.sv
// dma_desc_ring: DEPTH-entry in-order descriptor ring: load, tagged issue, out-of-order completion, in-order writeback.
// Optional DMA_DESC_TIMESTAMP_EN stamps a free-running cycle count into completed descriptors.
module dma_desc_ring
    import dma_desc_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int AXIS_DATA_WIDTH = 64,
    parameter int LEN_WIDTH       = 16,
    parameter int DEPTH           = 4,
    localparam int TAG_WIDTH      = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dma_desc_ring_if.slave       bus,
    output logic [TAG_WIDTH:0]   free_count,
    output logic                 tag_err
);
    localparam int BEATS = DESC_WIDTH / AXIS_DATA_WIDTH;
    localparam int CW    = TAG_WIDTH + 1;
    logic [TAG_WIDTH-1:0] load_ptr_q, load_ptr_d, issue_ptr_q, issue_ptr_d, wb_ptr_q, wb_ptr_d;
    logic [CW-1:0] pend_q, pend_d;
    logic beat_q, beat_d, wb_beat_q, wb_beat_d, tag_err_q, tag_err_d;
    logic [DESC_WIDTH-1:0] desc [DEPTH];
    slot_state_e state [DEPTH];
    logic load_acc, load_last, issue_hs, issue_adv, cpl_hit, wb_hs, wb_last;
`ifdef DMA_DESC_TIMESTAMP_EN
    logic [30:0] ts_q;
    always_ff @(posedge clk or negedge rst_n) ts_q <= !rst_n ? '0 : ts_q + 31'd1;
`endif
    assign bus.s_axis_desc_tready = rst_n && state[load_ptr_q] == FREE;
    assign load_acc  = bus.s_axis_desc_tvalid && bus.s_axis_desc_tready;
    assign load_last = beat_q == 1'(BEATS-1);
    assign bus.m_desc_valid = state[issue_ptr_q] == LOADED;
    assign bus.m_desc_addr  = desc[issue_ptr_q][DESC_ADDR_LSB +: AXI_ADDR_WIDTH];
    assign bus.m_desc_len   = desc[issue_ptr_q][DESC_LEN_LSB +: LEN_WIDTH];
    assign bus.m_desc_tag   = issue_ptr_q;
    assign issue_hs  = bus.m_desc_valid && bus.m_desc_ready;
    // pend counts slots loaded but not yet passed by issue_ptr, so a DONE slot there is a skipped one
    assign issue_adv = pend_q != '0 && (issue_hs || state[issue_ptr_q] == DONE);
    assign cpl_hit   = bus.s_axis_dma_desc_valid && state[bus.s_axis_dma_desc_tag] == ISSUED;
    assign bus.m_axis_wb_tvalid = state[wb_ptr_q] == DONE;
    assign bus.m_axis_wb_tdata  = desc[wb_ptr_q][int'(wb_beat_q)*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
    assign bus.m_axis_wb_tlast  = wb_last;
    assign wb_last = wb_beat_q == 1'(BEATS-1);
    assign wb_hs   = bus.m_axis_wb_tvalid && bus.m_axis_wb_tready;
    assign tag_err = tag_err_q;
    always_comb begin
        load_ptr_d  = load_ptr_q + TAG_WIDTH'(load_acc && load_last);
        beat_d      = load_acc ? (load_last ? 1'b0 : beat_q + 1'b1) : beat_q;
        issue_ptr_d = issue_ptr_q + TAG_WIDTH'(issue_adv);
        pend_d      = pend_q + CW'(load_acc && load_last) - CW'(issue_adv);
        wb_ptr_d    = wb_ptr_q + TAG_WIDTH'(wb_hs && wb_last);
        wb_beat_d   = wb_hs ? (wb_last ? 1'b0 : wb_beat_q + 1'b1) : wb_beat_q;
        tag_err_d   = tag_err_q || (bus.s_axis_dma_desc_valid && !cpl_hit);
    end
    always_comb begin
        free_count = '0;
        for (int i = 0; i < DEPTH; i++) free_count = free_count + CW'(state[i] == FREE);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_ptr_q  <= '0;
            issue_ptr_q <= '0;
            wb_ptr_q    <= '0;
            pend_q      <= '0;
            beat_q      <= 1'b0;
            wb_beat_q   <= 1'b0;
            tag_err_q   <= 1'b0;
        end else begin
            load_ptr_q  <= load_ptr_d;
            issue_ptr_q <= issue_ptr_d;
            wb_ptr_q    <= wb_ptr_d;
            pend_q      <= pend_d;
            beat_q      <= beat_d;
            wb_beat_q   <= wb_beat_d;
            tag_err_q   <= tag_err_d;
        end
    end
    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        dma_desc_slot #(
            .AXIS_DATA_WIDTH(AXIS_DATA_WIDTH),
            .LEN_WIDTH      (LEN_WIDTH)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load_i    (load_acc && load_ptr_q == TAG_WIDTH'(g)),
            .beat_i    (beat_q),
            .last_i    (load_last),
            .data_i    (bus.s_axis_desc_tdata),
            .issue_i   (issue_hs && issue_ptr_q == TAG_WIDTH'(g)),
            .complete_i(cpl_hit && bus.s_axis_dma_desc_tag == TAG_WIDTH'(g)),
            .len_i     (bus.s_axis_dma_desc_length),
`ifdef DMA_DESC_TIMESTAMP_EN
            .ts_i      (ts_q),
`endif
            .free_i    (wb_hs && wb_last && wb_ptr_q == TAG_WIDTH'(g)),
            .desc_o    (desc[g]),
            .state_o   (state[g])
        );
    end
endmodule

// File: tb/tb_dma_desc_ring.sv
// tb_dma_desc_ring: directed bench for the descriptor ring (DEPTH=4, 64-bit stream).
module tb_dma_desc_ring;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [2:0] free_count;
    logic tag_err;
    int n_cmp = 0;
    int n_err = 0;
    dma_desc_ring_if #(.AXI_ADDR_WIDTH(32), .AXIS_DATA_WIDTH(64), .LEN_WIDTH(16), .TAG_WIDTH(2)) bus();
    dma_desc_ring #(.AXI_ADDR_WIDTH(32), .AXIS_DATA_WIDTH(64), .LEN_WIDTH(16), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .free_count(free_count), .tag_err(tag_err)
    );
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic send_beat(input logic [63:0] d);
        int n = 0;
        bus.s_axis_desc_tdata  = d;
        bus.s_axis_desc_tvalid = 1'b1;
        while (bus.s_axis_desc_tready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (n == 100) begin
            n_cmp++; n_err++;
            $display("FAIL load_timeout: tready still %b after %0d cycles, want 1", bus.s_axis_desc_tready, n);
        end
        tick();
        bus.s_axis_desc_tvalid = 1'b0;
    endtask

    task automatic complete(input logic [1:0] tag, input logic [15:0] len);
        bus.s_axis_dma_desc_tag    = tag;
        bus.s_axis_dma_desc_length = len;
        bus.s_axis_dma_desc_valid  = 1'b1;
        tick();
        bus.s_axis_dma_desc_valid  = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_cmp++; if (bus.s_axis_desc_tready !== 1'b0) begin n_err++; $display("FAIL rst_tready: got %b want 0", bus.s_axis_desc_tready); end
        n_cmp++; if (bus.m_desc_valid !== 1'b0) begin n_err++; $display("FAIL rst_issue_valid: got %b want 0", bus.m_desc_valid); end
        n_cmp++; if (bus.m_axis_wb_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_wb_valid: got %b want 0", bus.m_axis_wb_tvalid); end
        n_cmp++; if (tag_err !== 1'b0) begin n_err++; $display("FAIL rst_tag_err: got %b want 0", tag_err); end
        n_cmp++; if (free_count !== 3'd4) begin n_err++; $display("FAIL rst_free: got %0d want 4", free_count); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if (bus.s_axis_desc_tready !== 1'b1) begin n_err++; $display("FAIL post_rst_tready: got %b want 1", bus.s_axis_desc_tready); end
    endtask

    task automatic test_issue();
        send_beat(64'h0000_0000_0000_1000);
        n_cmp++; if (bus.m_desc_valid !== 1'b0) begin n_err++; $display("FAIL issue_early: got %b want 0", bus.m_desc_valid); end
        send_beat(64'h0000_0001_0000_0800);
        n_cmp++; if (bus.m_desc_valid !== 1'b1) begin n_err++; $display("FAIL issue_valid: got %b want 1", bus.m_desc_valid); end
        n_cmp++; if (bus.m_desc_addr !== 32'h1000) begin n_err++; $display("FAIL issue_addr: got %h want 1000", bus.m_desc_addr); end
        n_cmp++; if (bus.m_desc_len !== 16'h0800) begin n_err++; $display("FAIL issue_len: got %h want 0800", bus.m_desc_len); end
        n_cmp++; if (bus.m_desc_tag !== 2'd0) begin n_err++; $display("FAIL issue_tag: got %0d want 0", bus.m_desc_tag); end
        n_cmp++; if (free_count !== 3'd3) begin n_err++; $display("FAIL issue_free: got %0d want 3", free_count); end
        bus.m_desc_ready = 1'b1;
        tick();
        bus.m_desc_ready = 1'b0;
        n_cmp++; if (bus.m_desc_valid !== 1'b0) begin n_err++; $display("FAIL issue_drop: got %b want 0", bus.m_desc_valid); end
    endtask

    task automatic test_complete();
        complete(2'd0, 16'h05EE);
        n_cmp++; if (bus.m_axis_wb_tvalid !== 1'b1) begin n_err++; $display("FAIL wb_valid: got %b want 1", bus.m_axis_wb_tvalid); end
        n_cmp++; if (bus.m_axis_wb_tdata !== 64'h0000_0000_0000_1000 || bus.m_axis_wb_tlast !== 1'b0) begin
            n_err++; $display("FAIL wb_beat0: got %h last %b want 0000000000001000 last 0", bus.m_axis_wb_tdata, bus.m_axis_wb_tlast); end
        bus.m_axis_wb_tready = 1'b1;
        tick();
        n_cmp++; if (bus.m_axis_wb_tdata !== 64'h0000_0000_0000_05EE || bus.m_axis_wb_tlast !== 1'b1) begin
            n_err++; $display("FAIL wb_beat1: got %h last %b want 00000000000005ee last 1", bus.m_axis_wb_tdata, bus.m_axis_wb_tlast); end
        tick();
        bus.m_axis_wb_tready = 1'b0;
        n_cmp++; if (bus.m_axis_wb_tvalid !== 1'b0) begin n_err++; $display("FAIL wb_end_valid: got %b want 0", bus.m_axis_wb_tvalid); end
        n_cmp++; if (free_count !== 3'd4) begin n_err++; $display("FAIL wb_end_free: got %0d want 4", free_count); end
    endtask

    task automatic test_order();
        logic [63:0] addr_tab [4] = '{64'h2000, 64'h2100, 64'h2200, 64'h2300};
        logic [15:0] len_tab [4] = '{16'h0010, 16'h0020, 16'h0030, 16'h0040};
        logic [15:0] cpl_tab [4] = '{16'h0100, 16'h0111, 16'h0222, 16'h0333};
        logic [1:0] cpl_order [4] = '{2'd2, 2'd0, 2'd3, 2'd1};
        logic [63:0] exp_wb [8];
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send_beat(addr_tab[i]);
            send_beat(64'h0000_0001_0000_0000 | 64'(len_tab[i]));
        end
        n_cmp++; if (free_count !== 3'd0) begin n_err++; $display("FAIL full_free: got %0d want 0", free_count); end
        n_cmp++; if (bus.s_axis_desc_tready !== 1'b0) begin n_err++; $display("FAIL full_tready: got %b want 0", bus.s_axis_desc_tready); end
        bus.m_desc_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (bus.m_desc_valid !== 1'b1 || bus.m_desc_tag !== 2'(i) || bus.m_desc_addr !== 32'(addr_tab[i]) || bus.m_desc_len !== len_tab[i]) begin
                n_err++; $display("FAIL order_issue%0d: got v%b tag %0d addr %h len %h want v1 tag %0d addr %h len %h",
                    i, bus.m_desc_valid, bus.m_desc_tag, bus.m_desc_addr, bus.m_desc_len, i, addr_tab[i], len_tab[i]); end
            tick();
        end
        bus.m_desc_ready = 1'b0;
        n_cmp++; if (bus.m_desc_valid !== 1'b0) begin n_err++; $display("FAIL all_issued_valid: got %b want 0", bus.m_desc_valid); end
        complete(cpl_order[0], cpl_tab[cpl_order[0]]);
        n_cmp++; if (bus.m_axis_wb_tvalid !== 1'b0) begin n_err++; $display("FAIL ooo_hold: got %b want 0", bus.m_axis_wb_tvalid); end
        for (int i = 1; i < 4; i++) complete(cpl_order[i], cpl_tab[cpl_order[i]]);
        for (int i = 0; i < 4; i++) begin
            exp_wb[2*i]   = addr_tab[i];
            exp_wb[2*i+1] = 64'(cpl_tab[i]);
        end
        bus.m_axis_wb_tready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            n_cmp++; if (bus.m_axis_wb_tvalid !== 1'b1 || bus.m_axis_wb_tdata !== exp_wb[k] || bus.m_axis_wb_tlast !== 1'(k % 2)) begin
                n_err++; $display("FAIL order_wb%0d: got v%b %h last %b want v1 %h last %0d",
                    k, bus.m_axis_wb_tvalid, bus.m_axis_wb_tdata, bus.m_axis_wb_tlast, exp_wb[k], k % 2); end
            n_cmp++; if (bus.s_axis_desc_tready !== (k >= 2)) begin
                n_err++; $display("FAIL stall_tready%0d: got %b want %b", k, bus.s_axis_desc_tready, k >= 2); end
            tick();
        end
        bus.m_axis_wb_tready = 1'b0;
        n_cmp++; if (free_count !== 3'd4 || bus.m_axis_wb_tvalid !== 1'b0) begin
            n_err++; $display("FAIL order_end: got free %0d v%b want free 4 v0", free_count, bus.m_axis_wb_tvalid); end
    endtask

    task automatic test_empty();
        do_reset();
        send_beat(64'hDEAD_BEEF_0000_3000);
        send_beat(64'hABCD_0000_1234_0040);
        n_cmp++; if (bus.m_desc_valid !== 1'b0) begin n_err++; $display("FAIL empty_issued: got %b want 0", bus.m_desc_valid); end
        n_cmp++; if (bus.m_axis_wb_tvalid !== 1'b1 || bus.m_axis_wb_tdata !== 64'hDEAD_BEEF_0000_3000) begin
            n_err++; $display("FAIL empty_wb0: got v%b %h want v1 deadbeef00003000", bus.m_axis_wb_tvalid, bus.m_axis_wb_tdata); end
        bus.m_axis_wb_tready = 1'b1;
        tick();
        n_cmp++; if (bus.m_axis_wb_tdata !== 64'hABCD_0000_1234_0040 || bus.m_axis_wb_tlast !== 1'b1) begin
            n_err++; $display("FAIL empty_wb1: got %h last %b want abcd000012340040 last 1", bus.m_axis_wb_tdata, bus.m_axis_wb_tlast); end
        tick();
        bus.m_axis_wb_tready = 1'b0;
        n_cmp++; if (bus.m_axis_wb_tvalid !== 1'b0 || bus.m_desc_valid !== 1'b0 || free_count !== 3'd4) begin
            n_err++; $display("FAIL empty_end: got wb v%b issue v%b free %0d want 0 0 4", bus.m_axis_wb_tvalid, bus.m_desc_valid, free_count); end
        send_beat(64'h0000_0000_0000_5000);
        send_beat(64'h0000_0001_0000_0050);
        n_cmp++; if (bus.m_desc_valid !== 1'b1 || bus.m_desc_tag !== 2'd1 || bus.m_desc_addr !== 32'h5000) begin
            n_err++; $display("FAIL skip_issue: got v%b tag %0d addr %h want v1 tag 1 addr 5000", bus.m_desc_valid, bus.m_desc_tag, bus.m_desc_addr); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        n_cmp++; if (tag_err !== 1'b0) begin n_err++; $display("FAIL rst_clears_err: got %b want 0", tag_err); end
        send_beat(64'h0000_0000_0000_4000);
        send_beat(64'h0000_0001_0000_0020);
        bus.m_desc_ready = 1'b1;
        complete(2'd0, 16'h0005);
        bus.m_desc_ready = 1'b0;
        n_cmp++; if (tag_err !== 1'b1 || bus.m_desc_valid !== 1'b0) begin
            n_err++; $display("FAIL same_cycle_err: got err %b issue v%b want err 1 v0", tag_err, bus.m_desc_valid); end
        tick();
        n_cmp++; if (bus.m_axis_wb_tvalid !== 1'b0) begin n_err++; $display("FAIL same_cycle_wb: got %b want 0", bus.m_axis_wb_tvalid); end
        complete(2'd0, 16'h0006);
        n_cmp++; if (bus.m_axis_wb_tvalid !== 1'b1 || bus.m_axis_wb_tdata !== 64'h4000) begin
            n_err++; $display("FAIL late_cpl_wb: got v%b %h want v1 4000", bus.m_axis_wb_tvalid, bus.m_axis_wb_tdata); end
        bus.m_axis_wb_tready = 1'b1;
        tick();
        n_cmp++; if (bus.m_axis_wb_tdata !== 64'h0000_0000_0000_0006) begin
            n_err++; $display("FAIL late_cpl_len: got %h want 0000000000000006", bus.m_axis_wb_tdata); end
        tick();
        bus.m_axis_wb_tready = 1'b0;
    endtask

    task automatic test_tag_err();
        do_reset();
        complete(2'd1, 16'h0077);
        n_cmp++; if (tag_err !== 1'b1) begin n_err++; $display("FAIL free_tag_err: got %b want 1", tag_err); end
        tick();
        n_cmp++; if (bus.m_axis_wb_tvalid !== 1'b0 || free_count !== 3'd4) begin
            n_err++; $display("FAIL free_tag_state: got v%b free %0d want v0 free 4", bus.m_axis_wb_tvalid, free_count); end
        repeat (3) tick();
        n_cmp++; if (tag_err !== 1'b1) begin n_err++; $display("FAIL tag_err_sticky: got %b want 1", tag_err); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_beat(64'h1111_2222_3333_4444);
        send_beat(64'h5555_6666_0000_0099);
        bus.m_axis_wb_tready = 1'b1;
        tick();
        bus.m_axis_wb_tready = 1'b0;
        repeat (10) tick();
        n_cmp++; if (bus.m_axis_wb_tvalid !== 1'b1 || bus.m_axis_wb_tdata !== 64'h5555_6666_0000_0099 || bus.m_axis_wb_tlast !== 1'b1) begin
            n_err++; $display("FAIL bp_hold: got v%b %h last %b want v1 5555666600000099 last 1",
                bus.m_axis_wb_tvalid, bus.m_axis_wb_tdata, bus.m_axis_wb_tlast); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.m_axis_wb_tvalid !== 1'b0 || free_count !== 3'd4 || bus.s_axis_desc_tready !== 1'b0 || tag_err !== 1'b0) begin
            n_err++; $display("FAIL mid_rst: got v%b free %0d tready %b err %b want v0 free 4 tready 0 err 0",
                bus.m_axis_wb_tvalid, free_count, bus.s_axis_desc_tready, tag_err); end
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++; if (bus.m_axis_wb_tvalid !== 1'b0 || bus.s_axis_desc_tready !== 1'b1 || free_count !== 3'd4) begin
            n_err++; $display("FAIL after_mid_rst: got v%b tready %b free %0d want v0 tready 1 free 4",
                bus.m_axis_wb_tvalid, bus.s_axis_desc_tready, free_count); end
    endtask

    initial begin
        bus.s_axis_desc_tdata      = '0;
        bus.s_axis_desc_tvalid     = 1'b0;
        bus.m_desc_ready           = 1'b0;
        bus.s_axis_dma_desc_length = '0;
        bus.s_axis_dma_desc_tag    = '0;
        bus.s_axis_dma_desc_valid  = 1'b0;
        bus.m_axis_wb_tready       = 1'b0;
        test_reset();
        test_issue();
        test_complete();
        test_order();
        test_empty();
        test_same_cycle();
        test_tag_err();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
